// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants for the VGA raster timing generator: default 640x480@60
// line/frame geometry, derived totals, coordinate width and the colour-bar
// table used by the optional test pattern (VGA_TIMING_TEST_PATTERN_EN).
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Must hold DEF_H_TOTAL-1 (799) and DEF_V_TOTAL-1 (524).
  localparam int DEF_CW       = 10;

  localparam int N_BARS       = 8;

  // Colour-bar table, left to right; 4 bits per channel, R in [11:8].
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF; // white
      3'd1:    c = 12'hFF0; // yellow
      3'd2:    c = 12'h0FF; // cyan
      3'd3:    c = 12'h0F0; // green
      3'd4:    c = 12'hF0F; // magenta
      3'd5:    c = 12'hF00; // red
      3'd6:    c = 12'h00F; // blue
      default: c = 12'h000; // black
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Raster timing bus from the timing generator to the pixel output stage.
// There is no valid/ready pair on this bus: the producer updates it once per
// pix_en cycle and the consumer samples every clock, qualifying (x, y, rgb)
// with active; line_start/frame_start are single-clock event pulses.
//   hsync, vsync        sync outputs (polarity set by the producer)
//   active              (x, y) lies in the visible area
//   x, y                current raster position, CW bits each
//   line_start          one-clock pulse at x=0 of every line
//   frame_start         one-clock pulse at x=0, y=0
//   rgb                 12-bit colour (test pattern or zero)
// Modports: master = timing generator, slave = pixel consumer.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int CW = DEF_CW
);
  logic          hsync;
  logic          vsync;
  logic          active;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic [11:0]   rgb;

  modport master (
    output hsync, vsync, active, x, y, line_start, frame_start, rgb
  );

  modport slave (
    input hsync, vsync, active, x, y, line_start, frame_start, rgb
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// Modulo-TOTAL up counter for one raster axis.
//   clock, reset  clock and asynchronous active-high reset
//   inc           advance by one this clock
//   cnt           current count, 0..TOTAL-1
//   wrap          high in the inc cycle where cnt is TOTAL-1 (combinational)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL,
  parameter int CW    = DEF_CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap
);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  assign wrap = inc && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing generator. Advances one pixel per clock with pix_en=1 and
// registers the decode of the current (h, v) position onto the timing bus, so
// the bus shows position (h, v) one clock after the pix_en cycle in which the
// counters held it. Sync/active/x/y/rgb hold while pix_en=0; line_start and
// frame_start clear on the next clock regardless of pix_en.
//   clock    system clock
//   reset    asynchronous active-high reset
//   pix_en   pixel strobe from the VGA clock divider
//   vid      vga_timing_gen_if.master timing bus (see interface header)
// Optional: define VGA_TIMING_TEST_PATTERN_EN to drive 8 vertical colour bars
// on vid.rgb; otherwise rgb is tied to 12'h000.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0,
  parameter int CW       = DEF_CW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_en,
  vga_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap_unused;

  vga_axis_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_h_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (pix_en),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  // Vertical advances only on the last pixel of a line.
  vga_axis_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_v_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap_unused)
  );

  logic hsync_d;
  logic vsync_d;
  logic active_d;
  logic h_zero;

  assign hsync_d  = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_ON : SYNC_OFF;
  assign vsync_d  = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_ON : SYNC_OFF;
  assign active_d = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign h_zero   = (h_cnt == '0);

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / N_BARS;

  logic [2:0]  bar_idx;
  logic [11:0] rgb_d;

  // Bar index is the highest bar whose left edge is at or left of h_cnt;
  // a compare chain avoids a divider for non power-of-two bar widths.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < N_BARS; i++) begin
      if (h_cnt >= CW'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
    rgb_d = active_d ? bar_colour(bar_idx) : 12'h000;
  end
`else
  assign vid.rgb = 12'h000;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vid.hsync       <= SYNC_OFF;
      vid.vsync       <= SYNC_OFF;
      vid.active      <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      vid.rgb         <= 12'h000;
`endif
    end else begin
      // Pulses are single-clock even when the next pix_en is far away.
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      if (pix_en) begin
        vid.hsync       <= hsync_d;
        vid.vsync       <= vsync_d;
        vid.active      <= active_d;
        vid.x           <= h_cnt;
        vid.y           <= v_cnt;
        vid.line_start  <= h_zero;
        vid.frame_start <= h_zero && (v_cnt == '0);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        vid.rgb         <= rgb_d;
`endif
      end
    end
  end
endmodule
